// File: rtl/scan_mux_pkg.sv
// scan_mux_pkg: shared definitions for the scan_mux channel multiplexer.
//   MODE_DIRECT / MODE_SCAN / MODE_HOLD : encodings of the 2-bit mode input
//                                         (2'b11 is decoded as direct).
//   sel_width(n_ch)                     : select/channel index width, max(1, ceil(log2(n_ch))).
package scan_mux_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_HOLD   = 2'b10;

  function automatic int unsigned sel_width(input int unsigned n_ch);
    return (n_ch > 1) ? $clog2(n_ch) : 1;
  endfunction

endpackage

// File: rtl/scan_mux_tick.sv
// scan_mux_tick: dwell counter for scan mode.
//   clock   : rising-edge clock
//   resetn  : asynchronous active-low reset
//   clear   : restart the dwell count at 0 (has priority over enable)
//   enable  : count one dwell cycle; wraps 0..DWELL-1
//   advance : high while enabled on the last dwell cycle, i.e. the channel must move on
module scan_mux_tick #(
  parameter int unsigned DWELL = 4
) (
  input  logic clock,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic advance
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == CNT_W'(DWELL - 1));
  assign advance = enable && !clear && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scan_mux.sv
// scan_mux: registered N_CH-way channel multiplexer with direct, scan and hold modes.
//   clock     : rising-edge clock
//   resetn    : asynchronous active-low reset
//   data_in   : N_CH channels of W bits, channel c at [c*W +: W]
//   sel       : direct-mode channel select / scan start channel
//   mode      : 00 direct, 01 scan, 10 hold, 11 direct
//   out       : registered data of the selected channel
//   out_valid : out carries an in-range channel
//   cur_ch    : channel index driving out
//   scan_wrap : one-cycle pulse when scan wraps N_CH-1 -> 0
// Build option: define SCAN_MUX_SCAN_EN to include scan mode; without it mode 01 acts as
// direct and no dwell/channel state exists.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter int unsigned  N_CH  = 7,
  parameter int unsigned  W     = 1,
  parameter int unsigned  DWELL = 4,
  localparam int unsigned SEL_W = sel_width(N_CH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic [N_CH*W-1:0] data_in,
  input  logic [SEL_W-1:0]  sel,
  input  logic [1:0]        mode,
  output logic [W-1:0]      out,
  output logic              out_valid,
  output logic [SEL_W-1:0]  cur_ch,
  output logic              scan_wrap
);

  if (N_CH < 2 || N_CH > 64 || W < 1 || W > 32 || DWELL < 1 || DWELL > 65535) begin : g_bad_param
    $error("scan_mux: parameter out of range");
  end

  function automatic logic [W-1:0] pick(input logic [N_CH*W-1:0] d,
                                        input logic [SEL_W-1:0]  idx);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (idx == SEL_W'(c)) v = d[c*W +: W];
    end
    return v;
  endfunction

  logic [W-1:0]     out_q, out_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] cur_q, cur_d;
  logic             wrap_q, wrap_d;
  logic             sel_ok;
  logic [W-1:0]     sel_data;

  assign sel_ok   = (32'(sel) < N_CH);
  assign sel_data = pick(data_in, sel);

`ifdef SCAN_MUX_SCAN_EN
  logic [SEL_W-1:0] ch_q, ch_d, scan_ch;
  logic [W-1:0]     scan_data;
  logic             resume_q;    // previous cycle was scan or hold: scan continues, no reload
  logic             scan_entry;
  logic             advance;
  logic             ch_last;

  assign scan_entry = (mode == MODE_SCAN) && !resume_q;
  assign ch_last    = (ch_q == SEL_W'(N_CH - 1));

  scan_mux_tick #(
    .DWELL (DWELL)
  ) u_tick (
    .clock   (clock),
    .resetn  (resetn),
    .clear   (scan_entry),
    .enable  ((mode == MODE_SCAN) && resume_q),
    .advance (advance)
  );

  // Channel shown on out after this edge while scanning.
  always_comb begin
    if (scan_entry) begin
      scan_ch = sel_ok ? sel : '0;
    end else if (advance) begin
      scan_ch = ch_last ? '0 : ch_q + SEL_W'(1);
    end else begin
      scan_ch = ch_q;
    end
  end

  assign scan_data = pick(data_in, scan_ch);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ch_q     <= '0;
      resume_q <= 1'b0;
    end else begin
      ch_q     <= ch_d;
      resume_q <= (mode == MODE_SCAN) || (mode == MODE_HOLD);
    end
  end
`endif

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    cur_d   = cur_q;
    wrap_d  = 1'b0;
`ifdef SCAN_MUX_SCAN_EN
    ch_d    = ch_q;
`endif
    if (mode == MODE_HOLD) begin
      // everything frozen, scan_wrap low
    end
`ifdef SCAN_MUX_SCAN_EN
    else if (mode == MODE_SCAN) begin
      ch_d    = scan_ch;
      out_d   = scan_data;
      valid_d = 1'b1;
      cur_d   = scan_ch;
      wrap_d  = !scan_entry && advance && ch_last;
    end
`endif
    else begin
      cur_d   = sel;
      valid_d = sel_ok;
      out_d   = sel_ok ? sel_data : '0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      cur_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      cur_q   <= cur_d;
      wrap_q  <= wrap_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;
  assign cur_ch    = cur_q;
  assign scan_wrap = wrap_q;

endmodule

// File: doc/scan_mux.md
SCAN_MUX -- requirements
Module: scan_mux

Interface
REQ-001 SHALL have parameter N_CH, default 7: number of input channels, range 2..64.
REQ-002 SHALL have parameter W, default 1: bits per channel, range 1..32.
REQ-003 SHALL have parameter DWELL, default 4: clock cycles spent on each channel in scan mode, range 1..65535.
REQ-004 SHALL derive SEL_W = max(1, ceil(log2(N_CH))), not user-settable.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 resetn  in  1  asynchronous, active-low reset.
REQ-007 data_in  in  N_CH*W  channel c occupies bits [c*W+W-1 : c*W].
REQ-008 sel  in  SEL_W  channel select in direct mode; scan start channel.
REQ-009 mode  in  2  00 direct, 01 scan, 10 hold, 11 direct.
REQ-010 out  out  W  registered selected channel data.
REQ-011 out_valid  out  1  high when out carries an in-range channel.
REQ-012 cur_ch  out  SEL_W  channel index driving out.
REQ-013 scan_wrap  out  1  one-cycle pulse on scan wrap N_CH-1 -> 0.

Function
REQ-014 Direct mode SHALL give out = data_in[sel] on the next edge, with 1-cycle latency; cur_ch <= sel; out_valid <= 1.
REQ-015 Direct mode with sel >= N_CH SHALL give out <= 0, out_valid <= 0, and cur_ch <= sel.
REQ-016 Scan mode SHALL register out <= data_in[ch] every cycle, so data changes on the active channel propagate with 1-cycle latency.
REQ-017 Scan mode SHALL advance ch by 1 after DWELL cycles on a channel; the dwell counter runs 0..DWELL-1.
REQ-018 Scan mode SHALL wrap ch from N_CH-1 to 0 and assert scan_wrap for exactly the cycle cur_ch first reads 0.
REQ-019 On a transition into scan from any other mode, ch SHALL load sel (0 if sel >= N_CH) and the dwell counter SHALL clear.
REQ-020 Hold mode SHALL freeze out, out_valid, cur_ch, ch and the dwell counter; scan_wrap = 0.
REQ-021 Leaving hold for scan SHALL resume from the frozen ch and dwell count; REQ-019 does not apply for hold -> scan.
REQ-022 With DWELL = 1, scan SHALL advance ch every cycle.
REQ-023 Mode 11 SHALL behave exactly as mode 00.
REQ-024 scan_wrap SHALL be 0 in every mode other than scan.

Reset
REQ-025 resetn low SHALL immediately force out = 0, out_valid = 0, cur_ch = 0, scan_wrap = 0, ch = 0 and dwell counter = 0.
REQ-026 Reset asserted mid-scan SHALL discard all progress; the first edge after release SHALL behave per the sampled mode, with scan treated as entry (REQ-019).

Configuration
REQ-027 The macro SCAN_MUX_SCAN_EN SHALL gate the scan feature.
REQ-028 With SCAN_MUX_SCAN_EN defined, the block SHALL behave as in REQ-016..REQ-022.
REQ-029 Without SCAN_MUX_SCAN_EN, mode 01 SHALL behave as direct mode, scan_wrap SHALL be tied to 0, and no dwell or ch registers SHALL be synthesised.

Structure
REQ-030 Package scan_mux_pkg SHALL hold the mode encodings (MODE_DIRECT, MODE_SCAN, MODE_HOLD) and the SEL_W width function.
REQ-031 One sub-module, scan_mux_tick, SHALL implement the dwell counter and its advance pulse, with clear and enable inputs.

Verification
REQ-032 Reset: N_CH=7, W=1, data_in=7'b1010101, resetn low mid-run -> out=0, out_valid=0, cur_ch=0 in the same cycle, before any clock edge.
REQ-033 Direct: sel=3, data_in=7'b0001000 -> out=1, out_valid=1, cur_ch=3 after 1 edge; then sel=7 -> out=0, out_valid=0 after 1 edge.
REQ-034 Scan: DWELL=4, sel=5, mode 00 -> 01 -> cur_ch=5 for 4 cycles, then 6 for 4 cycles, then 0 with scan_wrap high for 1 cycle.
REQ-035 Hold: scanning with cur_ch=2 after 1 dwell cycle, mode=10 for 10 cycles -> all outputs unchanged; on return to 01, cur_ch=2 for 3 more cycles, then 3.
REQ-036 Width: N_CH=4, W=8, data_in=32'hDDCCBBAA, DWELL=1, scan -> out sequence AA, BB, CC, DD, AA with scan_wrap on the second AA.
REQ-037 Macro off: mode=01, sel=4 -> out tracks data_in[4] and cur_ch stays 4 for 20 cycles; scan_wrap is never asserted.
